// File: rtl/wb_stage.sv
// Write-back stage: load-data extension, register-file write and forwarding,
// plus a small commit-trace FIFO that back-pressures the pipe when full.
module wb_stage #(
  parameter int TRACE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] result,
  input  logic [31:0] result_bypass,
  input  logic [31:0] PC,
  input  logic [7:0]  mem_op,
  input  logic        res_from_mem,
  input  logic        gr_we,
  input  logic [4:0]  dest,
  input  logic [31:0] data_sram_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        fwd_we,
  output logic [4:0]  fwd_dest,
  output logic [31:0] fwd_data,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [3:0]  trace_rf_we,
  output logic [4:0]  trace_rf_wnum,
  output logic [31:0] trace_rf_wdata,
  output logic [63:0] retire_cnt
);

  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TRACE_DEPTH);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          hold_vld_q, hold_vld_d;
  logic [31:0]   rdata_hold_q, rdata_hold_d;
  logic [63:0]   retire_cnt_q, retire_cnt_d;

  logic [31:0] pc_mem    [TRACE_DEPTH];
  logic [3:0]  we_mem    [TRACE_DEPTH];
  logic [4:0]  wnum_mem  [TRACE_DEPTH];
  logic [31:0] wdata_mem [TRACE_DEPTH];

  logic        full;
  logic        pop;
  logic        ready_go;
  logic        commit;
  logic        dest_nz;
  logic [31:0] src;
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] wdata;

  // Store opcodes and the upper address bits play no part in write-back.
  logic unused_bits;
  assign unused_bits = ^{mem_op[7:5], result_bypass[31:2]};

  assign full        = (count_q == DEPTH_C);
  assign trace_valid = rst & (count_q != '0);
  assign pop         = trace_valid & trace_ready;
  assign ready_go    = ~full | pop;
  assign commit      = rst & in_valid & ready_go;
  assign in_ready    = rst & (~in_valid | ready_go);
  assign dest_nz     = (dest != 5'd0);

  // The SRAM only presents read data in the first WB cycle, so a stalled
  // load must use the copy captured at that point.
  assign src     = hold_vld_q ? rdata_hold_q : data_sram_rdata;
  assign off     = result_bypass[1:0];
  assign ld_byte = src[{off, 3'b000} +: 8];
  assign ld_half = src[{off[1], 4'b0000} +: 16];

  always_comb begin
    load_data = src;
    if (mem_op[0])      load_data = {{24{ld_byte[7]}}, ld_byte};
    else if (mem_op[1]) load_data = {24'd0, ld_byte};
    else if (mem_op[2]) load_data = {{16{ld_half[15]}}, ld_half};
    else if (mem_op[3]) load_data = {16'd0, ld_half};
  end

  assign wdata = res_from_mem ? load_data : result;

  assign rf_we    = commit & gr_we & dest_nz;
  assign rf_waddr = dest;
  assign rf_wdata = wdata;
  assign fwd_we   = rst & in_valid & gr_we & dest_nz;
  assign fwd_dest = dest;
  assign fwd_data = wdata;

  assign trace_pc       = trace_valid ? pc_mem[rd_ptr_q]    : 32'd0;
  assign trace_rf_we    = trace_valid ? we_mem[rd_ptr_q]    : 4'd0;
  assign trace_rf_wnum  = trace_valid ? wnum_mem[rd_ptr_q]  : 5'd0;
  assign trace_rf_wdata = trace_valid ? wdata_mem[rd_ptr_q] : 32'd0;
  assign retire_cnt     = retire_cnt_q;

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    hold_vld_d   = hold_vld_q;
    rdata_hold_d = rdata_hold_q;
    retire_cnt_d = retire_cnt_q;

    if (commit) begin
      wr_ptr_d     = wr_ptr_q + 1'b1;
      retire_cnt_d = retire_cnt_q + 64'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({commit, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (commit) begin
      hold_vld_d = 1'b0;
    end else if (in_valid & ~ready_go & ~hold_vld_q) begin
      hold_vld_d   = 1'b1;
      rdata_hold_d = data_sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      hold_vld_q   <= 1'b0;
      rdata_hold_q <= 32'd0;
      retire_cnt_q <= 64'd0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      hold_vld_q   <= hold_vld_d;
      rdata_hold_q <= rdata_hold_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Entry storage needs no reset: head fields are masked by trace_valid.
  always_ff @(posedge clk) begin
    if (commit) begin
      pc_mem[wr_ptr_q]    <= PC;
      we_mem[wr_ptr_q]    <= {4{gr_we}};
      wnum_mem[wr_ptr_q]  <= dest;
      wdata_mem[wr_ptr_q] <= wdata;
    end
  end

endmodule
